// File: rtl/arm_mem_pkg.sv
// Shared types for the data-memory handshake block: access-size encoding,
// controller state encoding and a small alignment helper.
package arm_mem_pkg;

    // Access size as carried on req_size.
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_e;

    // True when the size/offset pair cannot be served.
    // The reserved size counts as misaligned.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: byte strobes and replicated write data for
// stores, lane extraction with zero extension for loads.
module mem_lane_align
    import arm_mem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  strobe_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [31:0] shifted;

    // Lane under the address moved down to bit 0, for byte extraction.
    assign shifted = rword_i >> {addr_lo_i, 3'b000};

    // Decode strobes and align data for the requested size.
    always_comb begin
        strobe_o = 4'b0000;
        wdata_o  = 32'h0;
        rdata_o  = 32'h0;
        case (size_i)
            SZ_BYTE: begin
                strobe_o = 4'b0001 << addr_lo_i;
                wdata_o  = {4{wdata_i[7:0]}};
                rdata_o  = {24'h0, shifted[7:0]};
            end
            SZ_HALF: begin
                strobe_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o  = {2{wdata_i[15:0]}};
                rdata_o  = addr_lo_i[1] ? {16'h0, rword_i[31:16]} : {16'h0, rword_i[15:0]};
            end
            SZ_WORD: begin
                strobe_o = 4'b1111;
                wdata_o  = wdata_i;
                rdata_o  = rword_i;
            end
            default: begin
                strobe_o = 4'b0000;
                wdata_o  = 32'h0;
                rdata_o  = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/dmem_handshake.sv
// Single-outstanding data memory with valid/ready request and response
// channels, a programmable wait latency and byte/halfword/word access.
module dmem_handshake
    import arm_mem_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 64,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int ADDR_W = $clog2(DEPTH);

    // Elaboration-time parameter checks.
    if (DATA_W != 32) begin : g_bad_width
        $error("dmem_handshake: DATA_W must be 32");
    end
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("dmem_handshake: DEPTH must be a power of two >= 4");
    end
    if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
        $error("dmem_handshake: LATENCY must be 0..15");
    end

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        err_q;

    logic        accept;
    logic        enter_resp;

    // Operand view: in IDLE the live inputs (needed when LATENCY=0 commits on
    // the accept edge itself), otherwise the latched request.
    logic        op_we;
    logic [1:0]  op_size;
    logic [31:0] op_addr;
    logic [31:0] op_wdata;
    logic        op_err;
    logic [ADDR_W-1:0] op_idx;

    logic [3:0]  strobe;
    logic [31:0] wdata_al;
    logic [31:0] rd_word;
    logic [31:0] rd_aligned;
    logic        wr_en;

    assign op_we    = (state_q == IDLE) ? req_we    : we_q;
    assign op_size  = (state_q == IDLE) ? req_size  : size_q;
    assign op_addr  = (state_q == IDLE) ? req_addr  : addr_q;
    assign op_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
    assign op_idx   = op_addr[ADDR_W+1:2];

    // Out of range whenever any word-index bit above the array size is set.
    assign op_err = misaligned(op_size, op_addr[1:0]) || (op_addr[31:ADDR_W+2] != '0);

    // A write that lands on the same edge as reset is dropped.
    assign wr_en = enter_resp && op_we && !op_err && !reset;

    mem_lane_align u_align (
        .size_i    (op_size),
        .addr_lo_i (op_addr[1:0]),
        .wdata_i   (op_wdata),
        .rword_i   (rd_word),
        .strobe_o  (strobe),
        .wdata_o   (wdata_al),
        .rdata_o   (rd_aligned)
    );

    // Next-state, counter and handshake decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        enter_resp = 1'b0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    if (LATENCY == 0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State and wait counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Latch the request on accept and the error verdict on entering RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                we_q    <= req_we;
                size_q  <= req_size;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (enter_resp) begin
                err_q <= op_err;
            end
        end
    end

    // One byte-wide array per lane gives independent byte write enables;
    // contents survive reset.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] mem_q [DEPTH];
        logic [7:0] rd_q;

        // Byte-lane write and registered read, both on the edge entering RESP.
        always_ff @(posedge clk) begin
            if (wr_en && strobe[gi]) begin
                mem_q[op_idx] <= wdata_al[gi*8 +: 8];
            end
            if (enter_resp) begin
                rd_q <= mem_q[op_idx];
            end
        end

        assign rd_word[gi*8 +: 8] = rd_q;
    end

    assign resp_err   = resp_valid && err_q;
    assign resp_rdata = (resp_valid && !err_q && !we_q) ? rd_aligned : 32'h0;

endmodule

// File: tb/tb_dmem_handshake.sv
// Randomized and directed bench for dmem_handshake with three instances
// (LATENCY 1, 3 and 0) checked against a byte-addressed reference memory.
module tb_dmem_handshake;
    import arm_mem_pkg::*;

    localparam int NI    = 3;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset      [NI];
    logic        req_valid  [NI];
    logic        req_ready  [NI];
    logic        req_we     [NI];
    logic [1:0]  req_size   [NI];
    logic [31:0] req_addr   [NI];
    logic [31:0] req_wdata  [NI];
    logic        resp_valid [NI];
    logic        resp_ready [NI];
    logic [31:0] resp_rdata [NI];
    logic        resp_err   [NI];

    int total = 0;
    int bad   = 0;

    // Reference memory, byte addressed.
    logic [7:0] mdl [NI][4*DEPTH];

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        dmem_handshake #(
            .DATA_W  (32),
            .DEPTH   (DEPTH),
            .LATENCY (gi == 0 ? 1 : (gi == 1 ? 3 : 0))
        ) u_dut (
            .clk        (clk),
            .reset      (reset[gi]),
            .req_valid  (req_valid[gi]),
            .req_ready  (req_ready[gi]),
            .req_we     (req_we[gi]),
            .req_size   (req_size[gi]),
            .req_addr   (req_addr[gi]),
            .req_wdata  (req_wdata[gi]),
            .resp_valid (resp_valid[gi]),
            .resp_ready (resp_ready[gi]),
            .resp_rdata (resp_rdata[gi]),
            .resp_err   (resp_err[gi])
        );
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 0);
    endfunction

    function automatic bit model_err(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0)
               || ((a / 4) >= DEPTH);
    endfunction

    function automatic logic [31:0] model_rd(input int k, input logic [1:0] sz, input logic [31:0] a);
        int b;
        b = int'(a);
        case (sz)
            2'd0:    return {24'h0, mdl[k][b]};
            2'd1:    return {16'h0, mdl[k][b+1], mdl[k][b]};
            default: return {mdl[k][b+3], mdl[k][b+2], mdl[k][b+1], mdl[k][b]};
        endcase
    endfunction

    task automatic model_wr(input int k, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        int b;
        int n;
        b = int'(a);
        n = (sz == 2'd0) ? 1 : ((sz == 2'd1) ? 2 : 4);
        for (int i = 0; i < n; i++) begin
            mdl[k][b+i] = wd[i*8 +: 8];
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full request/response with resp_ready held high; checks latency,
    // error flag and load data against the model.
    task automatic txn(input int k, input bit we, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input string tag,
                       output logic [31:0] got_rdata, output logic got_err);
        int          waited;
        bit          e_err;
        logic [31:0] e_rdata;
        e_err   = model_err(sz, a);
        e_rdata = (e_err || we) ? 32'h0 : model_rd(k, sz, a);
        @(negedge clk);
        check({tag, ".ready"}, 32'(req_ready[k]), 32'd1);
        req_valid[k]  = 1'b1;
        req_we[k]     = we;
        req_size[k]   = sz;
        req_addr[k]   = a;
        req_wdata[k]  = wd;
        resp_ready[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid[k] = 1'b0;
        waited = 0;
        while (!resp_valid[k] && waited < 40) begin
            @(posedge clk);
            @(negedge clk);
            waited++;
        end
        check({tag, ".lat"}, 32'(waited), 32'(lat_of(k)));
        check({tag, ".err"}, 32'(resp_err[k]), 32'(e_err));
        check({tag, ".rdata"}, resp_rdata[k], e_rdata);
        got_rdata = resp_rdata[k];
        got_err   = resp_err[k];
        if (we && !e_err) model_wr(k, sz, a, wd);
        $display("txn %s: inst=%0d we=%0d size=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
                 tag, k, we, sz, a, wd, got_rdata, got_err, waited);
        @(posedge clk);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          waited;
        int          acc;

        for (int k = 0; k < NI; k++) begin
            reset[k]      = 1'b1;
            req_valid[k]  = 1'b0;
            req_we[k]     = 1'b0;
            req_size[k]   = 2'b00;
            req_addr[k]   = 32'h0;
            req_wdata[k]  = 32'h0;
            resp_ready[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("rst%0d.req_ready", k), 32'(req_ready[k]), 32'd1);
            check($sformatf("rst%0d.resp_valid", k), 32'(resp_valid[k]), 32'd0);
            check($sformatf("rst%0d.resp_rdata", k), resp_rdata[k], 32'h0);
            check($sformatf("rst%0d.resp_err", k), 32'(resp_err[k]), 32'd0);
            reset[k] = 1'b0;
        end

        // Fill instance 0 so every later load has defined contents.
        for (int w = 0; w < DEPTH; w++) begin
            txn(0, 1'b1, SZ_WORD, 32'(w * 4), $urandom, "fill", rd, er);
        end

        // Word store then load at 0x64.
        txn(0, 1'b1, SZ_WORD, 32'h64, 32'h12345678, "st_w64", rd, er);
        txn(0, 1'b0, SZ_WORD, 32'h64, 32'h0, "ld_w64", rd, er);
        check("ld_w64.const", rd, 32'h12345678);

        // Byte merge into a word.
        txn(0, 1'b1, SZ_WORD, 32'h60, 32'h11223344, "st_w60", rd, er);
        txn(0, 1'b1, SZ_BYTE, 32'h61, 32'h000000AB, "st_b61", rd, er);
        txn(0, 1'b0, SZ_WORD, 32'h60, 32'h0, "ld_w60", rd, er);
        check("ld_w60.const", rd, 32'h1122AB44);
        txn(0, 1'b0, SZ_BYTE, 32'h61, 32'h0, "ld_b61", rd, er);
        check("ld_b61.const", rd, 32'h000000AB);

        // Misaligned accesses are rejected and write nothing.
        txn(0, 1'b0, SZ_HALF, 32'h63, 32'h0, "ld_h63", rd, er);
        check("ld_h63.errconst", 32'(er), 32'd1);
        txn(0, 1'b1, SZ_WORD, 32'h66, 32'hFFFFFFFF, "st_w66", rd, er);
        check("st_w66.errconst", 32'(er), 32'd1);
        txn(0, 1'b0, SZ_WORD, 32'h64, 32'h0, "ld_w64b", rd, er);
        check("ld_w64b.const", rd, 32'h12345678);

        // Response stall with a competing request that must be ignored.
        @(negedge clk);
        req_valid[0]  = 1'b1;
        req_we[0]     = 1'b0;
        req_size[0]   = SZ_WORD;
        req_addr[0]   = 32'h64;
        resp_ready[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        waited = 0;
        while (!resp_valid[0] && waited < 40) begin
            @(posedge clk);
            @(negedge clk);
            waited++;
        end
        check("stall.lat", 32'(waited), 32'd1);
        for (int c = 0; c < 5; c++) begin
            check($sformatf("stall%0d.valid", c), 32'(resp_valid[0]), 32'd1);
            check($sformatf("stall%0d.rdata", c), resp_rdata[0], 32'h12345678);
            check($sformatf("stall%0d.ready", c), 32'(req_ready[0]), 32'd0);
            $display("txn stall%0d: inst=0 valid=%0d rdata=%h req_ready=%0d",
                     c, resp_valid[0], resp_rdata[0], req_ready[0]);
            req_valid[0] = 1'b1;
            req_we[0]    = 1'b1;
            req_wdata[0] = 32'hDEADBEEF;
            @(posedge clk);
            @(negedge clk);
        end
        req_valid[0]  = 1'b0;
        resp_ready[0] = 1'b1;
        @(posedge clk);
        txn(0, 1'b0, SZ_WORD, 32'h64, 32'h0, "after_stall", rd, er);
        check("after_stall.const", rd, 32'h12345678);

        // Random mix of sizes, directions and addresses including out of range.
        for (int i = 0; i < 150; i++) begin
            txn(0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                32'($urandom_range(0, 4 * DEPTH + 15)), $urandom, "rand", rd, er);
        end

        // LATENCY=3: reset during the second WAIT cycle aborts a store.
        txn(1, 1'b1, SZ_WORD, 32'h64, 32'hCAFEBABE, "l3_st_old", rd, er);
        @(negedge clk);
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b1;
        req_size[1]  = SZ_WORD;
        req_addr[1]  = 32'h64;
        req_wdata[1] = 32'h7;
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("l3_wait.ready", 32'(req_ready[1]), 32'd0);
        check("l3_wait.valid", 32'(resp_valid[1]), 32'd0);
        reset[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset[1] = 1'b0;
        check("l3_rst.ready", 32'(req_ready[1]), 32'd1);
        check("l3_rst.valid", 32'(resp_valid[1]), 32'd0);
        $display("txn l3_abort: inst=1 req_ready=%0d resp_valid=%0d", req_ready[1], resp_valid[1]);
        txn(1, 1'b0, SZ_WORD, 32'h64, 32'h0, "l3_ld", rd, er);
        check("l3_ld.const", rd, 32'hCAFEBABE);

        // LATENCY=0: immediate response, throughput and range errors.
        txn(2, 1'b1, SZ_WORD, 32'h64, 32'h5A5A1234, "l0_st", rd, er);
        txn(2, 1'b0, SZ_HALF, 32'h66, 32'h0, "l0_ld_h", rd, er);
        check("l0_ld_h.const", rd, 32'h00005A5A);
        acc = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            req_valid[2]  = 1'b1;
            req_we[2]     = 1'b0;
            req_size[2]   = SZ_WORD;
            req_addr[2]   = 32'h64;
            resp_ready[2] = 1'b1;
            if (req_ready[2]) acc++;
            @(posedge clk);
        end
        @(negedge clk);
        req_valid[2] = 1'b0;
        check("l0_b2b.accepts", 32'(acc), 32'd10);
        $display("txn l0_b2b: inst=2 accepts=%0d in 20 cycles", acc);
        @(posedge clk);
        txn(2, 1'b0, SZ_WORD, 32'(4 * DEPTH), 32'h0, "l0_oor_ld", rd, er);
        check("l0_oor_ld.errconst", 32'(er), 32'd1);
        txn(2, 1'b1, SZ_BYTE, 32'(4 * DEPTH + 1), 32'h55, "l0_oor_st", rd, er);
        txn(2, 1'b0, SZ_RSVD, 32'h64, 32'h0, "l0_rsvd", rd, er);
        txn(2, 1'b0, SZ_WORD, 32'h64, 32'h0, "l0_ld_w", rd, er);
        check("l0_ld_w.const", rd, 32'h5A5A1234);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
